mon_exp_param: RTL and testbench

Parametrised successor to the existing Montgomery exponentiation block: computes base^e mod M with a self-contained radix-2 bit-serial Montgomery multiplier, left-to-right square-and-multiply and final domain conversion.
- Operands are supplied directly on ports; no BRAM traffic.
- Adds synchronous reset, a start/busy/stop handshake, operand validation and an error flag.
- Sits between the key-load logic and the RSA top level.

---
 rtl/mon_exp_param_if.sv | 28 ++
 rtl/mon_exp_param.sv | 217 +++++++++++++++++++++
 tb/tb_mon_exp_param.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mon_exp_param_if.sv
// Operand/handshake bundle for mon_exp_param: the requester (master) drives
// the operands and start; the exponentiator (slave) returns busy/stop/err/ans.
interface mon_exp_param_if #(
  parameter int WIDTH = 1024,
  parameter int EBITS = 1024,
  parameter int IDXW  = 10
);
  logic             start;
  logic [WIDTH-1:0] M;
  logic [WIDTH-1:0] base_bar;
  logic [WIDTH-1:0] one_bar;
  logic [EBITS-1:0] e;
  logic [IDXW-1:0]  e_idx;
  logic             busy;
  logic             stop;
  logic             err;
  logic [WIDTH-1:0] ans;

  modport master (
    output start, M, base_bar, one_bar, e, e_idx,
    input  busy, stop, err, ans
  );

  modport slave (
    input  start, M, base_bar, one_bar, e, e_idx,
    output busy, stop, err, ans
  );
endinterface

// File: rtl/mon_exp_param.sv
// Montgomery modular exponentiation (left-to-right square-and-multiply) with a
// bit-serial radix-2 MonPro. Define MONEXP_CONST_TIME_EN for fixed-latency mode.
module mon_exp_param #(
  parameter int WIDTH = 1024,
  parameter int EBITS = 1024,
  parameter int IDXW  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  mon_exp_param_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = WIDTH + 2;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
  localparam logic [31:0]      EBITS_U  = 32'(EBITS);
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQR  = 3'd1,
    ST_MUL  = 3'd2,
    ST_CONV = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [TW-1:0]    t_q, t_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [EBITS-1:0] e_q, e_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] ans_q, ans_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             stop_q, stop_d;

  logic [WIDTH-1:0] b_sel_s;
  logic [TW-1:0]    t_sum_s;
  logic [TW-1:0]    t_odd_s;
  logic [TW-1:0]    t_shift_s;
  logic [WIDTH-1:0] res_s;
  logic             op_last_s;
  logic             ebit_s;
  logic             bad_s;

  assign bus.busy = busy_q;
  assign bus.stop = stop_q;
  assign bus.err  = err_q;
  assign bus.ans  = ans_q;

  assign op_last_s = (cnt_q == CNT_LAST);
  assign ebit_s    = e_q[idx_q];
  assign bad_s     = (bus.M[0] == 1'b0) || (bus.M <= ONE_W) ||
                     ({{(32-IDXW){1'b0}}, bus.e_idx} >= EBITS_U);

  // One MonPro step: T = (T + A[i]*B + q*M) / 2, plus the final conditional subtract
  always_comb begin
    b_sel_s = x_q;
    case (state_q)
      ST_SQR:  b_sel_s = x_q;
      ST_MUL:  b_sel_s = base_q;
      ST_CONV: b_sel_s = ONE_W;
      default: b_sel_s = x_q;
    endcase
    t_sum_s   = t_q + (a_q[0] ? {2'b00, b_sel_s} : {TW{1'b0}});
    t_odd_s   = t_sum_s[0] ? (t_sum_s + {2'b00, m_q}) : t_sum_s;
    t_shift_s = t_odd_s >> 1;
    if (t_q >= {2'b00, m_q}) begin
      res_s = WIDTH'(t_q - {2'b00, m_q});
    end else begin
      res_s = t_q[WIDTH-1:0];
    end
  end

  // Sequencer next-state and working-register updates
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    base_d  = base_q;
    e_d     = e_q;
    idx_d   = idx_q;
    ans_d   = ans_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          m_d    = bus.M;
          base_d = bus.base_bar;
          e_d    = bus.e;
          idx_d  = bus.e_idx;
          x_d    = bus.one_bar;
          a_d    = bus.one_bar;
          t_d    = {TW{1'b0}};
          cnt_d  = {CW{1'b0}};
          if (bad_s) begin
            err_d   = 1'b1;
            ans_d   = {WIDTH{1'b0}};
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_SQR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SQR, ST_MUL, ST_CONV: begin
        if (!op_last_s) begin
          t_d   = t_shift_s;
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          a_d   = a_q >> 1;
        end else begin
          t_d   = {TW{1'b0}};
          cnt_d = {CW{1'b0}};
          case (state_q)
            ST_SQR: begin
              x_d = res_s;
`ifdef MONEXP_CONST_TIME_EN
              state_d = ST_MUL;
`else
              if (ebit_s) begin
                state_d = ST_MUL;
              end else if (idx_q == {IDXW{1'b0}}) begin
                state_d = ST_CONV;
              end else begin
                idx_d   = idx_q - {{(IDXW-1){1'b0}}, 1'b1};
                state_d = ST_SQR;
              end
`endif
            end
            ST_MUL: begin
`ifdef MONEXP_CONST_TIME_EN
              // Dummy multiply for zero bits keeps timing independent of e
              if (ebit_s) begin
                x_d = res_s;
              end else begin
                x_d = x_q;
              end
`else
              x_d = res_s;
`endif
              if (idx_q == {IDXW{1'b0}}) begin
                state_d = ST_CONV;
              end else begin
                idx_d   = idx_q - {{(IDXW-1){1'b0}}, 1'b1};
                state_d = ST_SQR;
              end
            end
            ST_CONV: begin
              ans_d   = res_s;
              state_d = ST_DONE;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
          a_d = x_d;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SQR) || (state_d == ST_MUL) || (state_d == ST_CONV);
    stop_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= {WIDTH{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      t_q     <= {TW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      m_q     <= {WIDTH{1'b0}};
      base_q  <= {WIDTH{1'b0}};
      e_q     <= {EBITS{1'b0}};
      idx_q   <= {IDXW{1'b0}};
      ans_q   <= {WIDTH{1'b0}};
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      base_q  <= base_d;
      e_q     <= e_d;
      idx_q   <= idx_d;
      ans_q   <= ans_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
    end
  end

endmodule

// File: tb/tb_mon_exp_param.sv
// Scoreboard bench for mon_exp_param at WIDTH=EBITS=16; honours MONEXP_CONST_TIME_EN.
module tb_mon_exp_param;

  localparam int W  = 16;
  localparam int EB = 16;
  localparam int IW = 4;
  localparam int MAX_CYC = 2000;

`ifdef MONEXP_CONST_TIME_EN
  localparam int LAT_E10 = 154;
  localparam int LAT_E0  = 52;
  localparam int LAT_E1  = 52;
`else
  localparam int LAT_E10 = 120;
  localparam int LAT_E0  = 35;
  localparam int LAT_E1  = 52;
`endif

  logic clk;
  logic rst_n;

  mon_exp_param_if #(.WIDTH(W), .EBITS(EB), .IDXW(IW)) ifc ();

  mon_exp_param #(.WIDTH(W), .EBITS(EB), .IDXW(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] ans;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int exp_latency(input logic [W-1:0] ev, input logic [IW-1:0] idx);
`ifdef MONEXP_CONST_TIME_EN
    return (2 * (int'(idx) + 1) + 1) * (W + 1) + 1;
`else
    int pc;
    pc = 0;
    for (int i = 0; i <= int'(idx); i++) pc += int'(ev[i]);
    return ((int'(idx) + 1) + pc) * (W + 1) + (W + 1) + 1;
`endif
  endfunction

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] m, input logic [W-1:0] b,
                                               input logic [W-1:0] ev, input logic [IW-1:0] idx);
    longint mm, bb, r;
    mm = longint'(m);
    bb = longint'(b);
    r  = 1 % mm;
    for (int i = int'(idx); i >= 0; i--) begin
      r = (r * r) % mm;
      if (ev[i]) r = (r * bb) % mm;
    end
    return W'(r);
  endfunction

  function automatic logic [W-1:0] to_mont(input logic [W-1:0] x, input logic [W-1:0] m);
    longint v;
    v = (longint'(x) << W) % longint'(m);
    return W'(v);
  endfunction

  // Start one operation and watch until stop, reset injection or cycle budget
  task automatic drive_op(input logic [W-1:0] m, input logic [W-1:0] bb, input logic [W-1:0] ob,
                          input logic [W-1:0] ev, input logic [IW-1:0] idx,
                          input int pulse_at, input int rst_at,
                          output int lat, output logic [W-1:0] got_ans, output logic got_err,
                          output logic got_stop, output logic busy_seen);
    logic quit;
    @(negedge clk);
    ifc.M        = m;
    ifc.base_bar = bb;
    ifc.one_bar  = ob;
    ifc.e        = ev;
    ifc.e_idx    = idx;
    ifc.start    = 1'b1;
    @(posedge clk);
    lat       = 0;
    got_stop  = 1'b0;
    busy_seen = 1'b0;
    got_ans   = '0;
    got_err   = 1'b0;
    quit      = 1'b0;
    while (!quit && lat < MAX_CYC) begin
      @(negedge clk);
      lat++;
      if (lat == 1 || lat == pulse_at + 1) ifc.start = 1'b0;
      if (ifc.busy) busy_seen = 1'b1;
      if (ifc.stop) begin
        got_stop = 1'b1;
        got_ans  = ifc.ans;
        got_err  = ifc.err;
        quit     = 1'b1;
      end else if (lat == pulse_at) begin
        ifc.M        = 16'd7;
        ifc.base_bar = 16'd0;
        ifc.e        = 16'hFFFF;
        ifc.e_idx    = 4'd15;
        ifc.start    = 1'b1;
      end
      if (lat == rst_at) begin
        rst_n = 1'b0;
        quit  = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.start = 1'b0;
    ifc.M = '0; ifc.base_bar = '0; ifc.one_bar = '0; ifc.e = '0; ifc.e_idx = '0;
    repeat (3) @(negedge clk);
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ifc.busy); end
    checks++; if (ifc.stop !== 1'b0) begin errors++; $display("FAIL reset_stop got %b want 0", ifc.stop); end
    checks++; if (ifc.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", ifc.err); end
    checks++; if (ifc.ans !== 16'd0) begin errors++; $display("FAIL reset_ans got %0d want 0", ifc.ans); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ifc.busy !== 1'b0 || ifc.stop !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b stop=%b want 0 0", ifc.busy, ifc.stop);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] ev_t [3];
    logic [W-1:0] ans_t [3];
    int           lat_t [3];
    logic [IW-1:0] idx_t [3];
    int lat; logic [W-1:0] a; logic er, st, bs; exp_t x;
    ev_t[0] = 16'd10; idx_t[0] = 4'd3; ans_t[0] = 16'd435; lat_t[0] = LAT_E10;
    ev_t[1] = 16'd0;  idx_t[1] = 4'd0; ans_t[1] = 16'd1;   lat_t[1] = LAT_E0;
    ev_t[2] = 16'd1;  idx_t[2] = 4'd0; ans_t[2] = 16'd2;   lat_t[2] = LAT_E1;
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back('{ans: ans_t[k], err: 1'b0, lat: lat_t[k]});
      drive_op(16'd589, 16'd314, 16'd157, ev_t[k], idx_t[k], 0, 0, lat, a, er, st, bs);
      x = sb_q.pop_front();
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL basic%0d_timeout no stop within %0d cycles", k, MAX_CYC); end
      checks++; if (a !== x.ans) begin errors++; $display("FAIL basic%0d_ans got %0d want %0d", k, a, x.ans); end
      checks++; if (er !== x.err) begin errors++; $display("FAIL basic%0d_err got %b want %b", k, er, x.err); end
      checks++; if (lat !== x.lat) begin errors++; $display("FAIL basic%0d_latency got %0d want %0d", k, lat, x.lat); end
      @(negedge clk);
      checks++; if (ifc.stop !== 1'b0) begin errors++; $display("FAIL basic%0d_stop_width stop still high, want one cycle", k); end
    end
  endtask

  task automatic test_invalid();
    int lat; logic [W-1:0] a; logic er, st, bs; exp_t x;
    sb_q.push_back('{ans: 16'd0, err: 1'b1, lat: 1});
    drive_op(16'd588, 16'd314, 16'd157, 16'd10, 4'd3, 0, 0, lat, a, er, st, bs);
    x = sb_q.pop_front();
    checks++; if (lat !== x.lat || st !== 1'b1) begin errors++; $display("FAIL invalid_latency got %0d want %0d", lat, x.lat); end
    checks++; if (er !== x.err) begin errors++; $display("FAIL invalid_err got %b want %b", er, x.err); end
    checks++; if (a !== x.ans) begin errors++; $display("FAIL invalid_ans got %0d want %0d", a, x.ans); end
    checks++; if (bs !== 1'b0) begin errors++; $display("FAIL invalid_busy got busy high want never"); end
    sb_q.push_back('{ans: 16'd435, err: 1'b0, lat: LAT_E10});
    drive_op(16'd589, 16'd314, 16'd157, 16'd10, 4'd3, 0, 0, lat, a, er, st, bs);
    x = sb_q.pop_front();
    checks++; if (er !== x.err) begin errors++; $display("FAIL after_invalid_err got %b want %b", er, x.err); end
    checks++; if (a !== x.ans) begin errors++; $display("FAIL after_invalid_ans got %0d want %0d", a, x.ans); end
  endtask

  task automatic test_restart_ignored();
    int lat; logic [W-1:0] a; logic er, st, bs; exp_t x; logic extra;
    sb_q.push_back('{ans: 16'd435, err: 1'b0, lat: LAT_E10});
    drive_op(16'd589, 16'd314, 16'd157, 16'd10, 4'd3, 50, 0, lat, a, er, st, bs);
    x = sb_q.pop_front();
    checks++; if (lat !== x.lat || st !== 1'b1) begin errors++; $display("FAIL restart_latency got %0d want %0d", lat, x.lat); end
    checks++; if (a !== x.ans) begin errors++; $display("FAIL restart_ans got %0d want %0d", a, x.ans); end
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    extra = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (ifc.busy || ifc.stop) extra = 1'b1;
      @(negedge clk);
    end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL start_in_stop_cycle got activity want ignored"); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [W-1:0] a; logic er, st, bs; exp_t x; logic act;
    drive_op(16'd589, 16'd314, 16'd157, 16'd10, 4'd3, 0, 60, lat, a, er, st, bs);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", ifc.busy); end
    checks++; if (ifc.ans !== 16'd0) begin errors++; $display("FAIL midreset_ans got %0d want 0", ifc.ans); end
    checks++; if (ifc.stop !== 1'b0) begin errors++; $display("FAIL midreset_stop got %b want 0", ifc.stop); end
    act = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ifc.stop || ifc.busy) act = 1'b1;
    end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL midreset_no_stop got activity want none"); end
    sb_q.push_back('{ans: 16'd435, err: 1'b0, lat: LAT_E10});
    drive_op(16'd589, 16'd314, 16'd157, 16'd10, 4'd3, 0, 0, lat, a, er, st, bs);
    x = sb_q.pop_front();
    checks++; if (a !== x.ans || st !== 1'b1) begin errors++; $display("FAIL after_reset_ans got %0d want %0d", a, x.ans); end
    checks++; if (lat !== x.lat) begin errors++; $display("FAIL after_reset_latency got %0d want %0d", lat, x.lat); end
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] a; logic er, st, bs; exp_t x;
    logic [W-1:0] m, b, ev; logic [IW-1:0] idx;
    for (int k = 0; k < 24; k++) begin
      m   = W'($urandom_range(1, 32767) * 2 + 1);
      b   = W'($urandom_range(0, int'(m) - 1));
      ev  = W'($urandom_range(0, 65535));
      idx = IW'($urandom_range(0, 15));
      sb_q.push_back('{ans: ref_modexp(m, b, ev, idx), err: 1'b0, lat: exp_latency(ev, idx)});
      drive_op(m, to_mont(b, m), to_mont(16'd1, m), ev, idx, 0, 0, lat, a, er, st, bs);
      x = sb_q.pop_front();
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL rand%0d_timeout no stop", k); end
      checks++; if (a !== x.ans) begin
        errors++; $display("FAIL rand%0d_ans M=%0d base=%0d e=%h idx=%0d got %0d want %0d", k, m, b, ev, idx, a, x.ans);
      end
      checks++; if (er !== x.err) begin errors++; $display("FAIL rand%0d_err got %b want %b", k, er, x.err); end
      checks++; if (lat !== x.lat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", k, lat, x.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
